ahb_lite_mem_arbiter: RTL and testbench

AHB_LITE_MEM_ARBITER -- requirements
Module: ahb_lite_mem_arbiter

---
 rtl/ahb_lite_mem_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_ahb_lite_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_mem_arbiter.sv
// ahb_lite_mem_arbiter
// Two-master front end for a single AHB-Lite memory slave (no HRESP).
//
// Handshake: a master request is valid in a cycle where M<m>_HREADY=1 and
// M<m>_HTRANS[1]=1. An issue slot is any cycle with S_HREADYOUT=1. In a slot
// with any request, exactly one transfer is driven to the slave. A valid live
// request that is not issued is captured into that master's pending register;
// while it is pending, the master sees HREADY=0 and holds its bus. The issued
// master owns the following data phase, which steers write data and gates that
// master's HREADY with S_HREADYOUT.
module ahb_lite_mem_arbiter #(
   parameter int unsigned PRIO_MODE = 0  // 0 = round-robin, 1 = fixed M0 priority
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic [31:0] M0_HADDR,
   input  logic [1:0]  M0_HTRANS,
   input  logic        M0_HWRITE,
   input  logic [2:0]  M0_HSIZE,
   input  logic [31:0] M0_HWDATA,
   output logic        M0_HREADY,
   output logic [31:0] M0_HRDATA,
   input  logic [31:0] M1_HADDR,
   input  logic [1:0]  M1_HTRANS,
   input  logic        M1_HWRITE,
   input  logic [2:0]  M1_HSIZE,
   input  logic [31:0] M1_HWDATA,
   output logic        M1_HREADY,
   output logic [31:0] M1_HRDATA,
   output logic        S_HSEL,
   output logic [31:0] S_HADDR,
   output logic [1:0]  S_HTRANS,
   output logic        S_HWRITE,
   output logic [2:0]  S_HSIZE,
   output logic [31:0] S_HWDATA,
   output logic        S_HREADY,
   input  logic        S_HREADYOUT,
   input  logic [31:0] S_HRDATA
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_M0   = 2'd1,
      OWN_M1   = 2'd2
   } owner_e;

   // Pending registers, one per master
   logic        pend0_q, pend1_q;
   logic [31:0] paddr0_q, paddr1_q;
   logic        pwrite0_q, pwrite1_q;
   logic [2:0]  psize0_q, psize1_q;

   // Arbitration history: 0 = M0 granted last, 1 = M1 granted last
   logic        last_grant_q;

   // Data-phase owner state
   owner_e      dp_owner_q, dp_owner_d;

   // Last issued address-phase control, held while nothing is issued
   logic [31:0] haddr_q;
   logic        hwrite_q;
   logic [2:0]  hsize_q;

   logic        live0, live1, req0, req1;
   logic        gnt_m1, issue, issue0, issue1;
   logic [31:0] iss_addr;
   logic        iss_write;
   logic [2:0]  iss_size;

   // Only HTRANS[1] distinguishes NONSEQ/SEQ from IDLE/BUSY
   logic        unused_htrans_lsb;
   assign unused_htrans_lsb = M0_HTRANS[0] ^ M1_HTRANS[0];

   // A pending master is stalled; the data-phase owner sees the slave's ready
   assign M0_HREADY = !pend0_q && ((dp_owner_q != OWN_M0) || S_HREADYOUT);
   assign M1_HREADY = !pend1_q && ((dp_owner_q != OWN_M1) || S_HREADYOUT);

   assign live0 = M0_HREADY && M0_HTRANS[1];
   assign live1 = M1_HREADY && M1_HTRANS[1];
   assign req0  = pend0_q || live0;
   assign req1  = pend1_q || live1;

   // Grant selection: single requester wins, otherwise mode-dependent
   always_comb begin
      gnt_m1 = 1'b0;
      if (req0 && req1) begin
         if (PRIO_MODE != 0) gnt_m1 = 1'b0;
         else                gnt_m1 = !last_grant_q;
      end else begin
         gnt_m1 = req1;
      end
   end

   assign issue  = S_HREADYOUT && (req0 || req1);
   assign issue0 = issue && !gnt_m1;
   assign issue1 = issue && gnt_m1;

   // Address-phase source: the pending copy takes precedence over the live bus
   always_comb begin
      iss_addr  = 32'h0;
      iss_write = 1'b0;
      iss_size  = 3'h0;
      if (gnt_m1) begin
         iss_addr  = pend1_q ? paddr1_q  : M1_HADDR;
         iss_write = pend1_q ? pwrite1_q : M1_HWRITE;
         iss_size  = pend1_q ? psize1_q  : M1_HSIZE;
      end else begin
         iss_addr  = pend0_q ? paddr0_q  : M0_HADDR;
         iss_write = pend0_q ? pwrite0_q : M0_HWRITE;
         iss_size  = pend0_q ? psize0_q  : M0_HSIZE;
      end
   end

   assign S_HSEL    = issue;
   assign S_HTRANS  = issue ? 2'b10 : 2'b00;
   assign S_HADDR   = issue ? iss_addr  : haddr_q;
   assign S_HWRITE  = issue ? iss_write : hwrite_q;
   assign S_HSIZE   = issue ? iss_size  : hsize_q;
   assign S_HREADY  = S_HREADYOUT;
   assign M0_HRDATA = S_HRDATA;
   assign M1_HRDATA = S_HRDATA;

   // Write data follows whichever master owns the data phase
   always_comb begin
      S_HWDATA = 32'h0;
      case (dp_owner_q)
         OWN_M0:  S_HWDATA = M0_HWDATA;
         OWN_M1:  S_HWDATA = M1_HWDATA;
         default: S_HWDATA = 32'h0;
      endcase
   end

   // Next data-phase owner: reloaded in every slot, held across wait states
   always_comb begin
      dp_owner_d = dp_owner_q;
      if (S_HREADYOUT) begin
         if (issue0)      dp_owner_d = OWN_M0;
         else if (issue1) dp_owner_d = OWN_M1;
         else             dp_owner_d = OWN_NONE;
      end
   end

   // Data-phase owner and arbitration history registers
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         dp_owner_q   <= OWN_NONE;
         last_grant_q <= 1'b1;
      end else begin
         dp_owner_q <= dp_owner_d;
         if (issue) last_grant_q <= gnt_m1;
      end
   end

   // Hold the last issued address-phase control for idle cycles
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         haddr_q  <= 32'h0;
         hwrite_q <= 1'b0;
         hsize_q  <= 3'h0;
      end else if (issue) begin
         haddr_q  <= iss_addr;
         hwrite_q <= iss_write;
         hsize_q  <= iss_size;
      end
   end

   // M0 pending register: clear on issue, capture an unissued live request
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         pend0_q   <= 1'b0;
         paddr0_q  <= 32'h0;
         pwrite0_q <= 1'b0;
         psize0_q  <= 3'h0;
      end else if (issue0) begin
         pend0_q <= 1'b0;
      end else if (live0) begin
         pend0_q   <= 1'b1;
         paddr0_q  <= M0_HADDR;
         pwrite0_q <= M0_HWRITE;
         psize0_q  <= M0_HSIZE;
      end
   end

   // M1 pending register: clear on issue, capture an unissued live request
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         pend1_q   <= 1'b0;
         paddr1_q  <= 32'h0;
         pwrite1_q <= 1'b0;
         psize1_q  <= 3'h0;
      end else if (issue1) begin
         pend1_q <= 1'b0;
      end else if (live1) begin
         pend1_q   <= 1'b1;
         paddr1_q  <= M1_HADDR;
         pwrite1_q <= M1_HWRITE;
         psize1_q  <= M1_HSIZE;
      end
   end

endmodule

// File: tb/tb_ahb_lite_mem_arbiter.sv
// Directed bench for ahb_lite_mem_arbiter: instance 0 is round-robin,
// instance 1 is fixed M0 priority; both see the same master/slave stimulus.
module tb_ahb_lite_mem_arbiter;

   logic        HCLK;
   logic        HRESET;
   logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata, s_hrdata;
   logic [1:0]  m0_htrans, m1_htrans;
   logic        m0_hwrite, m1_hwrite, s_hreadyout;
   logic [2:0]  m0_hsize, m1_hsize;

   logic [1:0]        m0_hready, m1_hready, s_hsel, s_hwrite, s_hready;
   logic [1:0][31:0]  m0_hrdata, m1_hrdata, s_haddr, s_hwdata;
   logic [1:0][1:0]   s_htrans;
   logic [1:0][2:0]   s_hsize;

   int checks   = 0;
   int failures = 0;
   int cnt_rr_m0, cnt_rr_m1, cnt_fx_m0, cnt_fx_m1;

   // Clock
   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   ahb_lite_mem_arbiter #(.PRIO_MODE(0)) u_rr (
      .HCLK(HCLK), .HRESET(HRESET),
      .M0_HADDR(m0_haddr), .M0_HTRANS(m0_htrans), .M0_HWRITE(m0_hwrite),
      .M0_HSIZE(m0_hsize), .M0_HWDATA(m0_hwdata), .M0_HREADY(m0_hready[0]),
      .M0_HRDATA(m0_hrdata[0]),
      .M1_HADDR(m1_haddr), .M1_HTRANS(m1_htrans), .M1_HWRITE(m1_hwrite),
      .M1_HSIZE(m1_hsize), .M1_HWDATA(m1_hwdata), .M1_HREADY(m1_hready[0]),
      .M1_HRDATA(m1_hrdata[0]),
      .S_HSEL(s_hsel[0]), .S_HADDR(s_haddr[0]), .S_HTRANS(s_htrans[0]),
      .S_HWRITE(s_hwrite[0]), .S_HSIZE(s_hsize[0]), .S_HWDATA(s_hwdata[0]),
      .S_HREADY(s_hready[0]), .S_HREADYOUT(s_hreadyout), .S_HRDATA(s_hrdata)
   );

   ahb_lite_mem_arbiter #(.PRIO_MODE(1)) u_fx (
      .HCLK(HCLK), .HRESET(HRESET),
      .M0_HADDR(m0_haddr), .M0_HTRANS(m0_htrans), .M0_HWRITE(m0_hwrite),
      .M0_HSIZE(m0_hsize), .M0_HWDATA(m0_hwdata), .M0_HREADY(m0_hready[1]),
      .M0_HRDATA(m0_hrdata[1]),
      .M1_HADDR(m1_haddr), .M1_HTRANS(m1_htrans), .M1_HWRITE(m1_hwrite),
      .M1_HSIZE(m1_hsize), .M1_HWDATA(m1_hwdata), .M1_HREADY(m1_hready[1]),
      .M1_HRDATA(m1_hrdata[1]),
      .S_HSEL(s_hsel[1]), .S_HADDR(s_haddr[1]), .S_HTRANS(s_htrans[1]),
      .S_HWRITE(s_hwrite[1]), .S_HSIZE(s_hsize[1]), .S_HWDATA(s_hwdata[1]),
      .S_HREADY(s_hready[1]), .S_HREADYOUT(s_hreadyout), .S_HRDATA(s_hrdata)
   );

   // Advance to just after the next rising edge
   task automatic cyc();
      @(posedge HCLK);
      #1;
   endtask

   task automatic do_reset();
      HRESET = 1'b1;
      cyc();
      HRESET = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive_m0(input logic [1:0] tr, input logic [31:0] a, input logic w,
                           input logic [31:0] wd);
      m0_htrans = tr; m0_haddr = a; m0_hwrite = w; m0_hwdata = wd; m0_hsize = 3'd2;
   endtask

   task automatic drive_m1(input logic [1:0] tr, input logic [31:0] a, input logic w,
                           input logic [31:0] wd);
      m1_htrans = tr; m1_haddr = a; m1_hwrite = w; m1_hwdata = wd; m1_hsize = 3'd2;
   endtask

   initial begin
      HRESET = 1'b1;
      s_hreadyout = 1'b1;
      s_hrdata = 32'h0;
      drive_m0(2'b00, 32'h0, 1'b0, 32'h0);
      drive_m1(2'b00, 32'h0, 1'b0, 32'h0);
      cyc();
      cyc();
      HRESET = 1'b0;

      // Reset state
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rst_hsel%0d", i),   s_hsel[i],    1'b0);
         chk($sformatf("rst_htrans%0d", i), s_htrans[i],  2'b00);
         chk($sformatf("rst_hwdata%0d", i), s_hwdata[i],  32'h0);
         chk($sformatf("rst_m0rdy%0d", i),  m0_hready[i], 1'b1);
         chk($sformatf("rst_m1rdy%0d", i),  m1_hready[i], 1'b1);
      end

      // Lone M0 read of 0x100 with a zero-wait slave
      cyc();
      drive_m0(2'b10, 32'h100, 1'b0, 32'h0);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rd_addr%0d", i),   s_haddr[i],   32'h100);
         chk($sformatf("rd_htrans%0d", i), s_htrans[i],  2'b10);
         chk($sformatf("rd_hsel%0d", i),   s_hsel[i],    1'b1);
         chk($sformatf("rd_m0rdy_a%0d", i), m0_hready[i], 1'b1);
      end
      cyc();
      drive_m0(2'b00, 32'h0, 1'b0, 32'h0);
      s_hrdata = 32'hCAFEF00D;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rd_data%0d", i),    m0_hrdata[i], 32'hCAFEF00D);
         chk($sformatf("rd_m0rdy_d%0d", i), m0_hready[i], 1'b1);
         chk($sformatf("rd_idle%0d", i),    s_htrans[i],  2'b00);
         chk($sformatf("rd_hold%0d", i),    s_haddr[i],   32'h100);
      end
      cyc();
      s_hrdata = 32'h0;

      // Simultaneous M0 read 0x0 / M1 write 0xDEADBEEF to 0x4 after reset
      do_reset();
      drive_m0(2'b10, 32'h0, 1'b0, 32'h0BADF00D);
      drive_m1(2'b10, 32'h4, 1'b1, 32'hDEADBEEF);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("both_addr0_%0d", i), s_haddr[i],  32'h0);
         chk($sformatf("both_wr0_%0d", i),   s_hwrite[i], 1'b0);
         chk($sformatf("both_tr0_%0d", i),   s_htrans[i], 2'b10);
      end
      cyc();
      drive_m0(2'b00, 32'h0, 1'b0, 32'h0BADF00D);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("both_m1rdy1_%0d", i), m1_hready[i], 1'b0);
         chk($sformatf("both_addr1_%0d", i),  s_haddr[i],   32'h4);
         chk($sformatf("both_wr1_%0d", i),    s_hwrite[i],  1'b1);
         chk($sformatf("both_tr1_%0d", i),    s_htrans[i],  2'b10);
         chk($sformatf("both_wd1_%0d", i),    s_hwdata[i],  32'h0BADF00D);
      end
      cyc();
      drive_m1(2'b00, 32'h0, 1'b0, 32'hDEADBEEF);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("both_wd2_%0d", i),    s_hwdata[i],  32'hDEADBEEF);
         chk($sformatf("both_m1rdy2_%0d", i), m1_hready[i], 1'b1);
         chk($sformatf("both_tr2_%0d", i),    s_htrans[i],  2'b00);
      end
      cyc();

      // Continuous contention for 8 slots
      do_reset();
      cnt_rr_m0 = 0; cnt_rr_m1 = 0; cnt_fx_m0 = 0; cnt_fx_m1 = 0;
      drive_m0(2'b10, 32'h1000, 1'b0, 32'h0);
      drive_m1(2'b10, 32'h2000, 1'b0, 32'h0);
      for (int k = 0; k < 8; k++) begin
         #1;
         chk($sformatf("rr_addr_k%0d", k), s_haddr[0], (k % 2 == 0) ? 32'h1000 : 32'h2000);
         chk($sformatf("fx_addr_k%0d", k), s_haddr[1], 32'h1000);
         chk($sformatf("fx_m1rdy_k%0d", k), m1_hready[1], (k == 0) ? 1'b1 : 1'b0);
         if (s_hsel[0] && s_haddr[0] == 32'h1000) cnt_rr_m0++;
         if (s_hsel[0] && s_haddr[0] == 32'h2000) cnt_rr_m1++;
         if (s_hsel[1] && s_haddr[1] == 32'h1000) cnt_fx_m0++;
         if (s_hsel[1] && s_haddr[1] == 32'h2000) cnt_fx_m1++;
         cyc();
      end
      chk("rr_cnt_m0", cnt_rr_m0, 32'd4);
      chk("rr_cnt_m1", cnt_rr_m1, 32'd4);
      chk("fx_cnt_m0", cnt_fx_m0, 32'd8);
      chk("fx_cnt_m1", cnt_fx_m1, 32'd0);
      drive_m0(2'b00, 32'h0, 1'b0, 32'h0);
      #1;
      chk("fx_m1_issue_addr", s_haddr[1],   32'h2000);
      chk("fx_m1_issue_tr",   s_htrans[1],  2'b10);
      chk("fx_m1_issue_rdy",  m1_hready[1], 1'b0);
      cyc();
      drive_m1(2'b00, 32'h0, 1'b0, 32'h0);
      cyc();

      // Two slave wait states on M0's data phase while M1 requests
      do_reset();
      drive_m0(2'b10, 32'h40, 1'b0, 32'h0);
      cyc();
      drive_m0(2'b00, 32'h0, 1'b0, 32'h0);
      drive_m1(2'b10, 32'h80, 1'b0, 32'h0);
      s_hreadyout = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("ws1_m0rdy%0d", i), m0_hready[i], 1'b0);
         chk($sformatf("ws1_m1rdy%0d", i), m1_hready[i], 1'b1);
         chk($sformatf("ws1_tr%0d", i),    s_htrans[i],  2'b00);
         chk($sformatf("ws1_sel%0d", i),   s_hsel[i],    1'b0);
      end
      cyc();
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("ws2_m0rdy%0d", i), m0_hready[i], 1'b0);
         chk($sformatf("ws2_m1rdy%0d", i), m1_hready[i], 1'b0);
         chk($sformatf("ws2_tr%0d", i),    s_htrans[i],  2'b00);
      end
      cyc();
      s_hreadyout = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("ws3_m0rdy%0d", i), m0_hready[i], 1'b1);
         chk($sformatf("ws3_tr%0d", i),    s_htrans[i],  2'b10);
         chk($sformatf("ws3_addr%0d", i),  s_haddr[i],   32'h80);
         chk($sformatf("ws3_m1rdy%0d", i), m1_hready[i], 1'b0);
      end
      cyc();
      drive_m1(2'b00, 32'h0, 1'b0, 32'h0);
      #1;
      for (int i = 0; i < 2; i++)
         chk($sformatf("ws4_m1rdy%0d", i), m1_hready[i], 1'b1);
      cyc();

      // Reset while M1 is pending and M0 owns a stalled data phase
      do_reset();
      drive_m0(2'b10, 32'h200, 1'b1, 32'h55AA55AA);
      cyc();
      drive_m0(2'b00, 32'h0, 1'b0, 32'h55AA55AA);
      drive_m1(2'b10, 32'h300, 1'b0, 32'h0);
      s_hreadyout = 1'b0;
      cyc();
      #1;
      for (int i = 0; i < 2; i++)
         chk($sformatf("rm_pend_m1rdy%0d", i), m1_hready[i], 1'b0);
      HRESET = 1'b1;
      cyc();
      HRESET = 1'b0;
      drive_m1(2'b00, 32'h0, 1'b0, 32'h0);
      s_hreadyout = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rm_m0rdy%0d", i), m0_hready[i], 1'b1);
         chk($sformatf("rm_m1rdy%0d", i), m1_hready[i], 1'b1);
         chk($sformatf("rm_tr%0d", i),    s_htrans[i],  2'b00);
         chk($sformatf("rm_sel%0d", i),   s_hsel[i],    1'b0);
         chk($sformatf("rm_wd%0d", i),    s_hwdata[i],  32'h0);
      end
      cyc();
      #1;
      for (int i = 0; i < 2; i++)
         chk($sformatf("rm_nodrop%0d", i), s_htrans[i], 2'b00);
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
